// File: rtl/dmem_arb_pkg.sv
// Shared types and RV32 load/store funct3 encodings for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {REQ_CPU = 1'b0, REQ_DBG = 1'b1} req_id_t;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} arb_state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick: on a tie, the side that did not win last time wins.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  req_id_t    last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_i == REQ_DBG) ? 2'b01 : 2'b10;
      default: gnt_o = '0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the CPU load/store path and the debug/loader master,
// tracking read latency and returning read data to the access owner.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  input  logic [2:0]    cpu_funct3_i,
  output logic          cpu_gnt_o,
  output logic          cpu_rvalid_o,
  output logic [DW-1:0] cpu_rdata_o,
  output logic          cpu_stall_o,
  input  logic          dbg_req_i,
  input  logic          dbg_we_i,
  input  logic [AW-1:0] dbg_addr_i,
  input  logic [DW-1:0] dbg_wdata_i,
  input  logic [2:0]    dbg_funct3_i,
  output logic          dbg_gnt_o,
  output logic          dbg_rvalid_o,
  output logic [DW-1:0] dbg_rdata_o,
  output logic [AW-1:0] mem_a_o,
  output logic [DW-1:0] mem_wd_o,
  output logic          mem_we_o,
  output logic [2:0]    mem_funct3_o,
  input  logic [DW-1:0] mem_rd_i
);

  localparam logic [2:0] CNT_LOAD = (RD_LATENCY == 0) ? 3'd0 : 3'(RD_LATENCY - 1);
  localparam logic       COMB_RD  = (RD_LATENCY == 0);

  arb_state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  req_id_t    owner_q, owner_d;
  req_id_t    rr_q, rr_d;

  logic       issue_win;
  logic       wait_done;
  logic [1:0] req_vec;
  logic [1:0] gnt;
  logic       any_gnt;
  logic       win_dbg;
  logic       win_we;
  logic       comb_rv;

  // Gating with rst keeps every strobe low while reset is held, even with requests asserted.
  assign wait_done = rst & (state_q == WAIT) & (cnt_q == '0);
  assign issue_win = rst & ((state_q == IDLE) | (cnt_q == '0));
  assign req_vec   = {dbg_req_i, cpu_req_i} & {2{issue_win}};

  rr_pick2 u_pick (
    .req_i  (req_vec),
    .last_i (rr_q),
    .gnt_o  (gnt)
  );

  assign any_gnt = |gnt;
  assign win_dbg = gnt[1];
  assign win_we  = win_dbg ? dbg_we_i : cpu_we_i;
  assign comb_rv = COMB_RD & any_gnt & ~win_we;

  always_comb begin
    mem_a_o      = '0;
    mem_wd_o     = '0;
    mem_we_o     = 1'b0;
    mem_funct3_o = '0;
    if (any_gnt) begin
      mem_a_o      = win_dbg ? dbg_addr_i   : cpu_addr_i;
      mem_wd_o     = win_dbg ? dbg_wdata_i  : cpu_wdata_i;
      mem_funct3_o = win_dbg ? dbg_funct3_i : cpu_funct3_i;
      mem_we_o     = win_we;
    end
  end

  assign cpu_gnt_o    = gnt[0];
  assign dbg_gnt_o    = gnt[1];
  assign cpu_rvalid_o = (wait_done & (owner_q == REQ_CPU)) | (comb_rv & ~win_dbg);
  assign dbg_rvalid_o = (wait_done & (owner_q == REQ_DBG)) | (comb_rv & win_dbg);
  assign cpu_rdata_o  = cpu_rvalid_o ? mem_rd_i : '0;
  assign dbg_rdata_o  = dbg_rvalid_o ? mem_rd_i : '0;
  assign cpu_stall_o  = cpu_req_i & ~(cpu_gnt_o & cpu_we_i) & ~cpu_rvalid_o;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    if (state_q == WAIT) begin
      if (cnt_q != '0) cnt_d = cnt_q - 3'd1;
      else             state_d = IDLE;
    end
    // A read granted in the rvalid cycle re-arms WAIT, overriding the return to IDLE.
    if (any_gnt) begin
      rr_d = win_dbg ? REQ_DBG : REQ_CPU;
      if (!win_we && !COMB_RD) begin
        state_d = WAIT;
        cnt_d   = CNT_LOAD;
        owner_d = win_dbg ? REQ_DBG : REQ_CPU;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= REQ_CPU;
      rr_q    <= REQ_DBG;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: four instances (RD_LATENCY 0..3) with per-instance memory models.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, dbg_addr = '0, dbg_wdata = '0;
  logic [2:0]  cpu_f3 = LW, dbg_f3 = LW;

  logic        cpu_gnt [4], cpu_rvalid [4], cpu_stall [4];
  logic        dbg_gnt [4], dbg_rvalid [4], mem_we [4];
  logic [31:0] cpu_rdata [4], dbg_rdata [4], mem_a [4], mem_wd [4], mem_rd [4];
  logic [2:0]  mem_f3 [4];

  typedef struct {
    req_id_t     id;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic cr, dr;
    logic e_cg, e_dg, e_cv, e_dv, e_st;
  } vec_t;
  vec_t tbl [7];

  int unsigned checks = 0, failures = 0;
  logic [1:0]  sel = 2'd1;
  logic [31:0] ref_mem [64];

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int unsigned i);
    init_word = (i == 2) ? 32'h1234_5678 : (32'hC0DE_0000 | 32'(i));
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic [31:0] mem [64];
    logic [31:0] pipe [3];
    initial for (int i = 0; i < 64; i++) mem[i] = init_word(i);
    always @(posedge clk) begin
      if (mem_we[g]) mem[mem_a[g][7:2]] <= mem_wd[g];
      pipe[0] <= mem[mem_a[g][7:2]];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    if (g == 0) begin : g_comb
      assign mem_rd[g] = mem[mem_a[g][7:2]];
    end else begin : g_pipe
      assign mem_rd[g] = pipe[g-1];
    end
    dmem_arbiter #(.RD_LATENCY(g), .AW(32), .DW(32)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .cpu_req_i    (cpu_req),
      .cpu_we_i     (cpu_we),
      .cpu_addr_i   (cpu_addr),
      .cpu_wdata_i  (cpu_wdata),
      .cpu_funct3_i (cpu_f3),
      .cpu_gnt_o    (cpu_gnt[g]),
      .cpu_rvalid_o (cpu_rvalid[g]),
      .cpu_rdata_o  (cpu_rdata[g]),
      .cpu_stall_o  (cpu_stall[g]),
      .dbg_req_i    (dbg_req),
      .dbg_we_i     (dbg_we),
      .dbg_addr_i   (dbg_addr),
      .dbg_wdata_i  (dbg_wdata),
      .dbg_funct3_i (dbg_f3),
      .dbg_gnt_o    (dbg_gnt[g]),
      .dbg_rvalid_o (dbg_rvalid[g]),
      .dbg_rdata_o  (dbg_rdata[g]),
      .mem_a_o      (mem_a[g]),
      .mem_wd_o     (mem_wd[g]),
      .mem_we_o     (mem_we[g]),
      .mem_funct3_o (mem_f3[g]),
      .mem_rd_i     (mem_rd[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every rvalid on the selected instance must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (cpu_gnt[sel] || dbg_gnt[sel])
      chk("gnt_excl", 32'(cpu_gnt[sel] & dbg_gnt[sel]), 32'd0);
    if (cpu_rvalid[sel] || dbg_rvalid[sel]) begin
      chk("rvalid_excl", 32'(cpu_rvalid[sel] & dbg_rvalid[sel]), 32'd0);
      if (sb.size() == 0) begin
        chk("sb_unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_owner", cpu_rvalid[sel] ? 32'(REQ_CPU) : 32'(REQ_DBG), 32'(e.id));
        chk("sb_data", cpu_rvalid[sel] ? cpu_rdata[sel] : dbg_rdata[sel], e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] s);
    tick();
    rst = 1'b0;
    cpu_req = 1'b0; dbg_req = 1'b0; cpu_we = 1'b0; dbg_we = 1'b0;
    tick();
    tick();
    sb.delete();
    sel = s;
    rst = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 12 && sb.size() != 0; i++) begin
      tick();
      @(negedge clk);
      #1;
    end
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

    // Reset state with both requests (one a store) asserted.
    cpu_req = 1'b1; cpu_we = 1'b1; dbg_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst%0d_cgnt", k), 32'(cpu_gnt[k]), 32'd0);
      chk($sformatf("rst%0d_dgnt", k), 32'(dbg_gnt[k]), 32'd0);
      chk($sformatf("rst%0d_crv", k), 32'(cpu_rvalid[k]), 32'd0);
      chk($sformatf("rst%0d_drv", k), 32'(dbg_rvalid[k]), 32'd0);
      chk($sformatf("rst%0d_we", k), 32'(mem_we[k]), 32'd0);
      chk($sformatf("rst%0d_crd", k), cpu_rdata[k], 32'd0);
      chk($sformatf("rst%0d_drd", k), dbg_rdata[k], 32'd0);
      chk($sformatf("rst%0d_addr", k), mem_a[k], 32'd0);
    end

    // Reset mid-read on the L=2 instance discards the pending read.
    do_reset(2'd2);
    tick(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100; cpu_f3 = LW;
    @(negedge clk); chk("A_gnt", 32'(cpu_gnt[2]), 32'd1);
    tick(); rst = 1'b0; cpu_req = 1'b0;
    @(negedge clk); chk("A_rv_in_rst", 32'(cpu_rvalid[2]), 32'd0);
    tick(); rst = 1'b1;
    @(negedge clk); chk("A_rv_T2", 32'(cpu_rvalid[2]), 32'd0);
    repeat (3) begin
      tick(); @(negedge clk); chk("A_rv_after", 32'(cpu_rvalid[2]), 32'd0);
    end
    tick();
    cpu_req = 1'b1; cpu_addr = 32'h10; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h14; dbg_f3 = LW;
    sb.push_back('{REQ_CPU, ref_mem[4]});
    sb.push_back('{REQ_DBG, ref_mem[5]});
    @(negedge clk); chk("A_first_cgnt", 32'(cpu_gnt[2]), 32'd1); chk("A_first_dgnt", 32'(dbg_gnt[2]), 32'd0);
    tick(); cpu_req = 1'b0;
    @(negedge clk); chk("A_T1_dgnt", 32'(dbg_gnt[2]), 32'd0);
    tick();
    @(negedge clk); chk("A_T2_dgnt", 32'(dbg_gnt[2]), 32'd1); chk("A_T2_crv", 32'(cpu_rvalid[2]), 32'd1);
    tick(); dbg_req = 1'b0;
    drain("A_drain");

    // Store then load of the same word on the L=1 instance.
    do_reset(2'd1);
    tick(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'hDEAD_BEEF; cpu_f3 = SW;
    @(negedge clk);
    chk("B_st_gnt", 32'(cpu_gnt[1]), 32'd1);
    chk("B_st_we", 32'(mem_we[1]), 32'd1);
    chk("B_st_stall", 32'(cpu_stall[1]), 32'd0);
    chk("B_st_addr", mem_a[1], 32'h20);
    chk("B_st_wd", mem_wd[1], 32'hDEAD_BEEF);
    chk("B_st_f3", 32'(mem_f3[1]), 32'(SW));
    ref_mem[8] = 32'hDEAD_BEEF;
    tick(); cpu_we = 1'b0; cpu_f3 = LW;
    sb.push_back('{REQ_CPU, ref_mem[8]});
    @(negedge clk);
    chk("B_ld_gnt", 32'(cpu_gnt[1]), 32'd1);
    chk("B_ld_we", 32'(mem_we[1]), 32'd0);
    chk("B_ld_stall", 32'(cpu_stall[1]), 32'd1);
    tick(); cpu_req = 1'b0;
    @(negedge clk);
    chk("B_rv", 32'(cpu_rvalid[1]), 32'd1);
    chk("B_rdata", cpu_rdata[1], 32'hDEAD_BEEF);
    drain("B_drain");

    // Continuous contention at L=1: grants alternate, each new grant lands on an rvalid.
    tbl[0] = '{1, 1, 1, 0, 0, 0, 1};
    tbl[1] = '{1, 1, 0, 1, 1, 0, 0};
    tbl[2] = '{1, 1, 1, 0, 0, 1, 1};
    tbl[3] = '{1, 1, 0, 1, 1, 0, 0};
    tbl[4] = '{0, 1, 0, 1, 0, 1, 0};
    tbl[5] = '{0, 0, 0, 0, 0, 1, 0};
    tbl[6] = '{0, 0, 0, 0, 0, 0, 0};
    do_reset(2'd1);
    cpu_we = 1'b0; dbg_we = 1'b0; cpu_addr = 32'h30; dbg_addr = 32'h34; cpu_f3 = LW; dbg_f3 = LW;
    for (int i = 0; i < 7; i++) begin
      tick();
      cpu_req = tbl[i].cr;
      dbg_req = tbl[i].dr;
      if (tbl[i].e_cg) sb.push_back('{REQ_CPU, ref_mem[12]});
      if (tbl[i].e_dg) sb.push_back('{REQ_DBG, ref_mem[13]});
      @(negedge clk);
      chk($sformatf("C%0d_cgnt", i), 32'(cpu_gnt[1]), 32'(tbl[i].e_cg));
      chk($sformatf("C%0d_dgnt", i), 32'(dbg_gnt[1]), 32'(tbl[i].e_dg));
      chk($sformatf("C%0d_crv", i), 32'(cpu_rvalid[1]), 32'(tbl[i].e_cv));
      chk($sformatf("C%0d_drv", i), 32'(dbg_rvalid[1]), 32'(tbl[i].e_dv));
      chk($sformatf("C%0d_stall", i), 32'(cpu_stall[1]), 32'(tbl[i].e_st));
    end
    drain("C_drain");

    // L=3: a debug store requested one cycle after a CPU load waits for the rvalid cycle.
    do_reset(2'd3);
    tick(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; cpu_f3 = LW;
    sb.push_back('{REQ_CPU, ref_mem[16]});
    @(negedge clk); chk("D_cgnt", 32'(cpu_gnt[3]), 32'd1);
    tick(); dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h44; dbg_wdata = 32'hCAFE_F00D; dbg_f3 = SW;
    @(negedge clk); chk("D_T1_dgnt", 32'(dbg_gnt[3]), 32'd0); chk("D_T1_stall", 32'(cpu_stall[3]), 32'd1);
    tick();
    @(negedge clk); chk("D_T2_dgnt", 32'(dbg_gnt[3]), 32'd0);
    tick();
    @(negedge clk);
    chk("D_T3_dgnt", 32'(dbg_gnt[3]), 32'd1);
    chk("D_T3_crv", 32'(cpu_rvalid[3]), 32'd1);
    chk("D_T3_we", 32'(mem_we[3]), 32'd1);
    chk("D_T3_addr", mem_a[3], 32'h44);
    ref_mem[17] = 32'hCAFE_F00D;
    tick(); cpu_req = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;
    @(negedge clk); chk("D_T4_dgnt", 32'(dbg_gnt[3]), 32'd0); chk("D_T4_drv", 32'(dbg_rvalid[3]), 32'd0);
    tick(); dbg_req = 1'b1; dbg_f3 = LW;
    sb.push_back('{REQ_DBG, ref_mem[17]});
    @(negedge clk); chk("D_ld_dgnt", 32'(dbg_gnt[3]), 32'd1);
    tick(); dbg_req = 1'b0;
    drain("D_drain");

    // L=0: grant and rvalid in the same cycle.
    do_reset(2'd0);
    tick(); dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h8; dbg_f3 = LW;
    sb.push_back('{REQ_DBG, 32'h1234_5678});
    @(negedge clk);
    chk("E_dgnt", 32'(dbg_gnt[0]), 32'd1);
    chk("E_drv", 32'(dbg_rvalid[0]), 32'd1);
    chk("E_rdata", dbg_rdata[0], 32'h1234_5678);
    chk("E_crv", 32'(cpu_rvalid[0]), 32'd0);
    tick(); dbg_req = 1'b0;
    drain("E_drain");

    // CPU withdraws while the debug read is in WAIT.
    do_reset(2'd2);
    tick(); dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h14; dbg_f3 = LW;
    sb.push_back('{REQ_DBG, ref_mem[5]});
    @(negedge clk); chk("F_dgnt", 32'(dbg_gnt[2]), 32'd1);
    tick(); dbg_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    @(negedge clk); chk("F_T1_cgnt", 32'(cpu_gnt[2]), 32'd0); chk("F_T1_stall", 32'(cpu_stall[2]), 32'd1);
    tick(); cpu_req = 1'b0;
    @(negedge clk);
    chk("F_T2_cgnt", 32'(cpu_gnt[2]), 32'd0);
    chk("F_T2_stall", 32'(cpu_stall[2]), 32'd0);
    chk("F_T2_drv", 32'(dbg_rvalid[2]), 32'd1);
    repeat (3) begin
      tick(); @(negedge clk); chk("F_no_cgnt", 32'(cpu_gnt[2]), 32'd0);
    end
    drain("F_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
